// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX arbiter slice.
//   AXIS_DATA_W        : byte-wide AXI-Stream data width used by every port
//   TIMEOUT_CYCLES_DEF : default mid-frame idle limit before a frame is aborted
//   arb_state_e        : arbiter FSM state encoding
package eth_pkg;

   localparam int AXIS_DATA_W        = 8;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Byte-wide AXI-Stream TX bundle shared by the requesters and the MAC side.
//   tdata/tlast/tuser/tvalid : driven by the stream source (master)
//   tready                   : driven by the stream sink (slave)
interface eth_tx_arbiter_if;
   import eth_pkg::*;

   logic [AXIS_DATA_W-1:0] tdata;
   logic                   tlast;
   logic                   tuser;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, output tlast, output tuser, output tvalid, input  tready);
   modport slave  (input  tdata, input  tlast, input  tuser, input  tvalid, output tready);

endinterface

// File: rtl/eth_tx_arb_rr.sv
// Two-way round-robin picker.
//   req_i[1:0]    : request per port
//   last_winner_i : index of the port that finished the previous frame
//   grant_o[1:0]  : one-hot winner, 2'b00 when nothing requests
module eth_tx_arb_rr
   import eth_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_winner_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         // Contention: the port after the last winner goes first.
         2'b11:   grant_o = last_winner_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one MAC TX AXI-Stream port
// between two requesters.
//   tx_mac_aclk : clock for all logic
//   glbl_rst    : asynchronous active-high reset
//   s0_axis_tx  : requester 0 stream (slave side of the bundle)
//   s1_axis_tx  : requester 1 stream (slave side of the bundle)
//   m_axis_tx   : stream towards the MAC (master side of the bundle)
//   grant       : one-hot current owner, 2'b00 when idle
//   abort_pulse : one-cycle strobe on the handshake of an abort beat
//   abort_cnt   : saturating count of aborted frames
// Build option ETH_TX_ARB_ABORT_EN enables the mid-frame idle timeout,
// the abort beat and the drain of the truncated frame; without it a
// granted frame may stall forever and the abort outputs are tied to zero.
module eth_tx_arbiter
   import eth_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int ABORT_CNT_W    = 16
) (
   input  logic                   tx_mac_aclk,
   input  logic                   glbl_rst,
   eth_tx_arbiter_if.slave        s0_axis_tx,
   eth_tx_arbiter_if.slave        s1_axis_tx,
   eth_tx_arbiter_if.master       m_axis_tx,
   output logic [1:0]             grant,
   output logic                   abort_pulse,
   output logic [ABORT_CNT_W-1:0] abort_cnt
);

   arb_state_e             state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic                   last_q, last_d;
   logic [1:0]             req, rr_gnt;
   logic                   sel;
   logic [AXIS_DATA_W-1:0] g_tdata, m_tdata;
   logic                   g_tlast, g_tuser, g_tvalid, g_tready;
   logic                   m_tlast, m_tuser, m_tvalid;

   assign req = {s1_axis_tx.tvalid, s0_axis_tx.tvalid};
   assign sel = grant_q[1];

   // Granted-port view; only meaningful while grant_q is non-zero.
   assign g_tdata  = sel ? s1_axis_tx.tdata  : s0_axis_tx.tdata;
   assign g_tlast  = sel ? s1_axis_tx.tlast  : s0_axis_tx.tlast;
   assign g_tuser  = sel ? s1_axis_tx.tuser  : s0_axis_tx.tuser;
   assign g_tvalid = sel ? s1_axis_tx.tvalid : s0_axis_tx.tvalid;

   eth_tx_arb_rr u_rr (
      .req_i         (req),
      .last_winner_i (last_q),
      .grant_o       (rr_gnt)
   );

`ifdef ETH_TX_ARB_ABORT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   tmo_hit, abort_hs;
   logic [ABORT_CNT_W-1:0] abort_cnt_q, abort_cnt_d;

   // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES; a
   // cycle with tvalid high clears the count instead, so it never aborts.
   assign tmo_hit = !g_tvalid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = tmo_q;
      if (state_q != ST_BUSY || g_tvalid) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   always_comb begin
      abort_cnt_d = abort_cnt_q;
      if (abort_hs && (abort_cnt_q != '1)) begin
         abort_cnt_d = abort_cnt_q + ABORT_CNT_W'(1);
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      m_tuser  = 1'b0;
      m_tvalid = 1'b0;
      g_tready = 1'b0;
`ifdef ETH_TX_ARB_ABORT_EN
      abort_hs = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d = rr_gnt;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            m_tdata  = g_tdata;
            m_tlast  = g_tlast;
            m_tuser  = g_tuser;
            m_tvalid = g_tvalid;
            g_tready = m_axis_tx.tready;
            if (g_tvalid && m_axis_tx.tready && g_tlast) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
               last_d  = sel;
            end
`ifdef ETH_TX_ARB_ABORT_EN
            else if (tmo_hit) begin
               state_d = ST_ABORT;
            end
`endif
         end
`ifdef ETH_TX_ARB_ABORT_EN
         // Closing beat marked bad so the MAC discards the partial frame.
         ST_ABORT: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tuser  = 1'b1;
            if (m_axis_tx.tready) begin
               state_d  = ST_DRAIN;
               abort_hs = 1'b1;
            end
         end
         // Swallow the rest of the abandoned frame up to its tlast.
         ST_DRAIN: begin
            g_tready = 1'b1;
            if (g_tvalid && g_tlast) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
               last_d  = sel;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge tx_mac_aclk or posedge glbl_rst) begin
      if (glbl_rst) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef ETH_TX_ARB_ABORT_EN
   always_ff @(posedge tx_mac_aclk or posedge glbl_rst) begin
      if (glbl_rst) begin
         tmo_q       <= '0;
         abort_cnt_q <= '0;
      end else begin
         tmo_q       <= tmo_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign abort_pulse = abort_hs;
   assign abort_cnt   = abort_cnt_q;
`else
   assign abort_pulse = 1'b0;
   assign abort_cnt   = '0;
`endif

   assign m_axis_tx.tdata   = m_tdata;
   assign m_axis_tx.tlast   = m_tlast;
   assign m_axis_tx.tuser   = m_tuser;
   assign m_axis_tx.tvalid  = m_tvalid;
   assign s0_axis_tx.tready = g_tready & grant_q[0];
   assign s1_axis_tx.tready = g_tready & grant_q[1];
   assign grant             = grant_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-requester beat queues feed the
// stream drivers, expected MAC-side beats are queued as frames are queued
// and compared in order as the MAC side accepts them.
module tb_eth_tx_arbiter;

   typedef struct packed {
      logic [7:0]  data;
      logic        last;
      logic [15:0] gap;
   } beat_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
      logic       src;
      logic       gap_chk;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  grant;
   logic        abort_pulse;
   logic [15:0] abort_cnt;

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   int idle_run = 0;
   int pulse_seen = 0;
   logic mrdy_rand = 1'b0;

   beat_t src_q [2][$];
   exp_t  exp_q [$];
   exp_t  mon_e;

   logic       drv_valid [2];
   logic [7:0] drv_data  [2];
   logic       drv_last  [2];
   logic       fresh     [2];
   int         gap_left  [2];
   logic       acc       [2];

   eth_tx_arbiter_if s0_if ();
   eth_tx_arbiter_if s1_if ();
   eth_tx_arbiter_if m_if ();

   assign s0_if.tvalid = drv_valid[0];
   assign s0_if.tdata  = drv_data[0];
   assign s0_if.tlast  = drv_last[0];
   assign s0_if.tuser  = 1'b0;
   assign s1_if.tvalid = drv_valid[1];
   assign s1_if.tdata  = drv_data[1];
   assign s1_if.tlast  = drv_last[1];
   assign s1_if.tuser  = 1'b0;

   eth_tx_arbiter #(
      .TIMEOUT_CYCLES (16),
      .ABORT_CNT_W    (16)
   ) dut (
      .tx_mac_aclk (clk),
      .glbl_rst    (rst),
      .s0_axis_tx  (s0_if),
      .s1_axis_tx  (s1_if),
      .m_axis_tx   (m_if),
      .grant       (grant),
      .abort_pulse (abort_pulse),
      .abort_cnt   (abort_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // MAC-side ready: constant high or a fair coin per cycle.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = mrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Requester drivers: advance on an observed handshake, honour per-beat gaps.
   initial begin
      for (int p = 0; p < 2; p++) begin
         drv_valid[p] = 1'b0;
         drv_data[p]  = 8'h00;
         drv_last[p]  = 1'b0;
         fresh[p]     = 1'b1;
         gap_left[p]  = 0;
      end
      forever begin
         @(negedge clk);
         acc[0] = s0_if.tvalid && s0_if.tready;
         acc[1] = s1_if.tvalid && s1_if.tready;
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (rst) begin
               src_q[p].delete();
               fresh[p]    = 1'b1;
               gap_left[p] = 0;
            end else if (acc[p] && src_q[p].size() > 0) begin
               void'(src_q[p].pop_front());
               fresh[p] = 1'b1;
            end
            if (fresh[p] && src_q[p].size() > 0) begin
               gap_left[p] = int'(src_q[p][0].gap);
               fresh[p]    = 1'b0;
            end
            if (src_q[p].size() > 0 && gap_left[p] == 0) begin
               drv_valid[p] = 1'b1;
               drv_data[p]  = src_q[p][0].data;
               drv_last[p]  = src_q[p][0].last;
            end else begin
               drv_valid[p] = 1'b0;
               if (gap_left[p] > 0) gap_left[p]--;
            end
         end
      end
   end

   // MAC-side monitor / scoreboard comparison.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (abort_pulse) pulse_seen++;
            if (m_if.tvalid && m_if.tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data=%02h last=%0b user=%0b, required no beat", m_if.tdata, m_if.tlast, m_if.tuser);
               end else begin
                  mon_e = exp_q.pop_front();
                  checks++;
                  if ({m_if.tdata, m_if.tlast, m_if.tuser} !== {mon_e.data, mon_e.last, mon_e.user}) begin
                     errors++;
                     $display("FAIL beat_data: got data=%02h last=%0b user=%0b, required data=%02h last=%0b user=%0b", m_if.tdata, m_if.tlast, m_if.tuser, mon_e.data, mon_e.last, mon_e.user);
                  end
                  checks++;
                  if (grant !== (mon_e.src ? 2'b10 : 2'b01)) begin
                     errors++;
                     $display("FAIL beat_owner: got grant=%02b, required source %0d", grant, mon_e.src);
                  end
                  checks++;
                  if (abort_pulse !== mon_e.user) begin
                     errors++;
                     $display("FAIL beat_abort_pulse: got %0b, required %0b", abort_pulse, mon_e.user);
                  end
                  if (mon_e.gap_chk) begin
                     checks++;
                     if (idle_run !== 1) begin
                        errors++;
                        $display("FAIL frame_gap: got %0d idle cycles, required 1", idle_run);
                     end
                  end
               end
               beat_cnt++;
               idle_run = 0;
            end else if (!m_if.tvalid) begin
               idle_run++;
            end
         end
      end
   end

   task automatic add_frame(input int p, input int len, input int stall_after,
                            input int stall_len, input int n_exp, input bit gap_first);
      beat_t b;
      exp_t  e;
      for (int i = 1; i <= len; i++) begin
         b.data = 8'($urandom);
         b.last = (i == len);
         b.gap  = (stall_after > 0 && i == stall_after + 1) ? 16'(stall_len) : 16'd0;
         src_q[p].push_back(b);
         if (i <= n_exp) begin
            e.data    = b.data;
            e.last    = b.last;
            e.user    = 1'b0;
            e.src     = p[0];
            e.gap_chk = gap_first && (i == 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d beats still pending after %0d cycles, required 0", name, exp_q.size(), n);
         exp_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin
         errors++;
         $display("FAIL %s_idle_grant: got %02b, required 00", name, grant);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %02b, required 00", grant); end
      checks++;
      if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %0b, required 0", m_if.tvalid); end
      checks++;
      if ({s1_if.tready, s0_if.tready} !== 2'b00) begin errors++; $display("FAIL rst_tready: got %02b, required 00", {s1_if.tready, s0_if.tready}); end
      checks++;
      if (abort_pulse !== 1'b0) begin errors++; $display("FAIL rst_abort_pulse: got %0b, required 0", abort_pulse); end
      checks++;
      if (abort_cnt !== 16'd0) begin errors++; $display("FAIL rst_abort_cnt: got %0d, required 0", abort_cnt); end
      #2 rst = 1'b0;
   endtask

   task automatic test_single_frame();
      int n = 0;
      int base = beat_cnt;
      add_frame(0, 64, 0, 0, 64, 1'b0);
      while (!s0_if.tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (s0_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_src_valid: got %0b, required 1", s0_if.tvalid); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_arb: got %02b, required 00", grant); end
      @(negedge clk);
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL single_grant_latency: got %02b, required 01", grant); end
      wait_done("single", 300);
      checks++;
      if (beat_cnt - base !== 64) begin errors++; $display("FAIL single_beats: got %0d, required 64", beat_cnt - base); end
   endtask

   task automatic test_back_to_back();
      int base;
      do_reset();
      base = beat_cnt;
      add_frame(0, 12, 0, 0, 12, 1'b0);
      add_frame(1, 9,  0, 0, 9,  1'b1);
      add_frame(0, 5,  0, 0, 5,  1'b1);
      add_frame(1, 14, 0, 0, 14, 1'b1);
      add_frame(0, 7,  0, 0, 7,  1'b1);
      add_frame(1, 3,  0, 0, 3,  1'b1);
      wait_done("b2b", 400);
      checks++;
      if (beat_cnt - base !== 50) begin errors++; $display("FAIL b2b_beats: got %0d, required 50", beat_cnt - base); end
   endtask

   task automatic test_tready_toggle();
      int n = 0;
      int s1_cycles = 0;
      mrdy_rand = 1'b1;
      add_frame(0, 4,  0, 0, 4,  1'b0);
      add_frame(1, 40, 0, 0, 40, 1'b0);
      add_frame(0, 6,  0, 0, 6,  1'b0);
      while (exp_q.size() > 0 && n < 1000) begin
         @(negedge clk);
         n++;
         if (grant == 2'b10) begin
            s1_cycles++;
            checks++;
            if (s0_if.tready !== 1'b0) begin errors++; $display("FAIL toggle_s0_tready: got %0b, required 0", s0_if.tready); end
         end
      end
      mrdy_rand = 1'b0;
      wait_done("toggle", 100);
      checks++;
      if (s1_cycles < 40) begin errors++; $display("FAIL toggle_s1_owned: got %0d cycles, required at least 40", s1_cycles); end
   endtask

   task automatic test_stall_below_timeout();
      int p0 = pulse_seen;
      add_frame(0, 32, 10, 15, 32, 1'b0);
      wait_done("stall15", 300);
      checks++;
      if (abort_cnt !== 16'd0) begin errors++; $display("FAIL stall15_abort_cnt: got %0d, required 0", abort_cnt); end
      checks++;
      if (pulse_seen - p0 !== 0) begin errors++; $display("FAIL stall15_pulses: got %0d, required 0", pulse_seen - p0); end
   endtask

`ifdef ETH_TX_ARB_ABORT_EN
   task automatic test_abort();
      int   n = 0;
      int   p0 = pulse_seen;
      exp_t e;
      add_frame(0, 40, 10, 16, 10, 1'b0);
      e.data    = 8'h00;
      e.last    = 1'b1;
      e.user    = 1'b1;
      e.src     = 1'b0;
      e.gap_chk = 1'b0;
      exp_q.push_back(e);
      while (grant !== 2'b01 && n < 20) begin
         @(negedge clk);
         n++;
      end
      add_frame(1, 16, 0, 0, 16, 1'b0);
      wait_done("abort", 400);
      checks++;
      if (abort_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt: got %0d, required 1", abort_cnt); end
      checks++;
      if (pulse_seen - p0 !== 1) begin errors++; $display("FAIL abort_pulses: got %0d, required 1", pulse_seen - p0); end
      checks++;
      if (src_q[0].size() !== 0) begin errors++; $display("FAIL abort_drain: got %0d s0 beats left, required 0", src_q[0].size()); end
   endtask
`else
   task automatic test_long_stall();
      int p0 = pulse_seen;
      add_frame(0, 24, 10, 20, 24, 1'b0);
      wait_done("longstall", 300);
      checks++;
      if (abort_cnt !== 16'd0) begin errors++; $display("FAIL longstall_abort_cnt: got %0d, required 0", abort_cnt); end
      checks++;
      if (pulse_seen - p0 !== 0) begin errors++; $display("FAIL longstall_pulses: got %0d, required 0", pulse_seen - p0); end
   endtask
`endif

   task automatic test_reset_mid_frame();
      int n = 0;
      int base = beat_cnt;
      int p0;
      add_frame(0, 64, 0, 0, 64, 1'b0);
      while (!(beat_cnt == base + 20 && m_if.tvalid) && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      checks++;
      if (beat_cnt != base + 20) begin errors++; $display("FAIL midrst_reach: got %0d beats, required 20", beat_cnt - base); end
      rst = 1'b1;
      #1;
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL midrst_grant: got %02b, required 00", grant); end
      checks++;
      if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid: got %0b, required 0", m_if.tvalid); end
      checks++;
      if (s0_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_s0_tready: got %0b, required 0", s0_if.tready); end
      checks++;
      if (abort_cnt !== 16'd0) begin errors++; $display("FAIL midrst_abort_cnt: got %0d, required 0", abort_cnt); end
      checks++;
      if (abort_pulse !== 1'b0) begin errors++; $display("FAIL midrst_abort_pulse: got %0b, required 0", abort_pulse); end
      exp_q.delete();
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      p0 = pulse_seen;
      add_frame(0, 8, 0, 0, 8, 1'b0);
      add_frame(1, 8, 0, 0, 8, 1'b1);
      wait_done("midrst", 200);
      checks++;
      if (pulse_seen - p0 !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d, required 0", pulse_seen - p0); end
      checks++;
      if (abort_cnt !== 16'd0) begin errors++; $display("FAIL midrst_abort_cnt_after: got %0d, required 0", abort_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_tready_toggle();
      test_stall_below_timeout();
`ifdef ETH_TX_ARB_ABORT_EN
      test_abort();
`else
      test_long_stall();
`endif
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
